data_memory: RTL and testbench

//   Word-addressed data RAM for the MEM stage of the pipelined CPU.

---
 rtl/data_memory_if.sv | 35 +++
 rtl/data_memory.sv | 75 +++++++
 tb/tb_data_memory.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// Bus bundle for the MEM-stage data RAM.
// The CPU side uses the master modport and the RAM uses the slave modport.
// When DMEM_BOUNDS_CHECK_EN is defined, the bundle also carries the err flag.
interface data_memory_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       addr;
  logic [DATA_W-1:0] write_data;
  logic              memwrite;
  logic              memread;
  logic [DATA_W-1:0] read_data;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic              err;

  modport master (
    output addr, write_data, memwrite, memread,
    input  read_data, err
  );

  modport slave (
    input  addr, write_data, memwrite, memread,
    output read_data, err
  );
`else
  modport master (
    output addr, write_data, memwrite, memread,
    input  read_data
  );

  modport slave (
    input  addr, write_data, memwrite, memread,
    output read_data
  );
`endif
endinterface

// File: rtl/data_memory.sv
// Word-addressed data RAM for the MEM stage of the pipelined CPU.
// Writes are synchronous on the rising clock edge.
// Reads are combinational and are gated by memread.
// The whole array clears asynchronously while rst_n is low.
// Optional macro DMEM_BOUNDS_CHECK_EN:
//   - An address at or above DEPTH suppresses the write.
//   - That address also forces read_data to 0.
//   - The bus err flag is driven for such an access.
// Without the macro, the address wraps modulo DEPTH.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  data_memory_if.slave  bus
);

  // Storage: one register per word.
  // The asynchronous whole-array clear rules out a block RAM.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Word index: the low address bits.
  logic [IDX_W-1:0] idx;
  assign idx = bus.addr[IDX_W-1:0];

  // in_range: low whenever any upper address bit is set, if bounds checking is enabled.
  logic in_range;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign in_range = ~|bus.addr[31:IDX_W];
`else
  assign in_range = 1'b1;
`endif

  // Qualified write strobe, shared by every word's decode.
  logic write_ok;
  assign write_ok = bus.memwrite & in_range;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic word_sel;
      assign word_sel = write_ok && (idx == IDX_W'(gi));

      // Each word clears asynchronously on reset and loads write_data when selected.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (word_sel) begin
          mem_reg[gi] <= bus.write_data;
        end
      end
    end
  endgenerate

  // Combinational read port: zero unless memread is set and the address is valid.
  always_comb begin
    bus.read_data = '0;
    if (bus.memread && in_range) begin
      bus.read_data = mem_reg[idx];
    end
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  // err flags an out-of-range access, but never while reset is held.
  always_comb begin
    bus.err = 1'b0;
    if (rst_n && (bus.memread || bus.memwrite) && !in_range) begin
      bus.err = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// Phase 1 applies a table of directed vectors.
// Phase 2 runs hand-written multi-cycle sequences: simultaneous read/write and asynchronous reset.
// Phase 3 applies random traffic and compares it against an array reference model.
// If DMEM_BOUNDS_CHECK_EN is defined, the bench also checks err.
module tb_data_memory;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = 8;

  logic clk;
  logic rst_n;

  data_memory_if #(.DATA_W(DATA_W)) bus ();

  data_memory #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: a plain array of words.
  logic [DATA_W-1:0] model [DEPTH];

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
    return a >= 32'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re);
    bus.addr       = a;
    bus.write_data = wd;
    bus.memwrite   = we;
    bus.memread    = re;
  endtask

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] EXP_W2   = 32'd54;
  localparam logic [31:0] EXP_R258 = 32'd0;
`else
  localparam logic [31:0] EXP_W2   = 32'd11;
  localparam logic [31:0] EXP_R258 = 32'd11;
`endif

  initial begin
    string nm;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] exp_rd;

    drive(32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: {addr, write_data, memwrite, memread, expected read_data before edge, expected err}.
    vecs.push_back('{32'd2,   32'd0,  1'b0, 1'b1, 32'd0,  1'b0});
    vecs.push_back('{32'd9,   32'd0,  1'b0, 1'b1, 32'd0,  1'b0});
    vecs.push_back('{32'd3,   32'd0,  1'b0, 1'b1, 32'd0,  1'b0});
    vecs.push_back('{32'd2,   32'd54, 1'b1, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd9,   32'd16, 1'b1, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd3,   32'd62, 1'b1, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd3,   32'd0,  1'b0, 1'b1, 32'd62, 1'b0});
    vecs.push_back('{32'd9,   32'd0,  1'b0, 1'b1, 32'd16, 1'b0});
    vecs.push_back('{32'd2,   32'd0,  1'b0, 1'b1, 32'd54, 1'b0});
    vecs.push_back('{32'd3,   32'd50, 1'b1, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd3,   32'd50, 1'b0, 1'b1, 32'd50, 1'b0});
    vecs.push_back('{32'd3,   32'd0,  1'b0, 1'b1, 32'd50, 1'b0});
    vecs.push_back('{32'd3,   32'd62, 1'b1, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd3,   32'd0,  1'b0, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd3,   32'd0,  1'b0, 1'b1, 32'd62, 1'b0});
    vecs.push_back('{32'd5,   32'd7,  1'b1, 1'b0, 32'd0,  1'b0});
    vecs.push_back('{32'd5,   32'd99, 1'b1, 1'b1, 32'd7,  1'b0});
    vecs.push_back('{32'd5,   32'd0,  1'b0, 1'b1, 32'd99, 1'b0});
    vecs.push_back('{32'd258, 32'd11, 1'b1, 1'b0, 32'd0,  1'b1});
    vecs.push_back('{32'd2,   32'd0,  1'b0, 1'b1, EXP_W2, 1'b0});
    vecs.push_back('{32'd258, 32'd0,  1'b0, 1'b1, EXP_R258, 1'b1});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].re);
      #1;
      nm = $sformatf("vec%0d_rd", i);
      check(nm, bus.read_data, vecs[i].exp_rd);
`ifdef DMEM_BOUNDS_CHECK_EN
      nm = $sformatf("vec%0d_err", i);
      check(nm, {31'd0, bus.err}, {31'd0, vecs[i].exp_err});
`endif
      $display("vec %0d addr=%0d wd=%0d we=%0b re=%0b rd=%0d", i, vecs[i].addr, vecs[i].wd,
               vecs[i].we, vecs[i].re, bus.read_data);
    end

    // Simultaneous read/write: the old word is visible before the edge and the new word after it,
    // while the inputs are held.
    @(negedge clk);
    drive(32'd6, 32'd17, 1'b1, 1'b0);
    @(negedge clk);
    drive(32'd6, 32'd123, 1'b1, 1'b1);
    #1;
    check("rw_before_edge", bus.read_data, 32'd17);
    @(posedge clk);
    #1;
    check("rw_after_edge", bus.read_data, 32'd123);
    $display("rw addr=6 before=17 after=%0d", bus.read_data);

    // Asynchronous reset in mid-cycle: contents clear immediately and writes are ignored.
    @(negedge clk);
    drive(32'd3, 32'd0, 1'b0, 1'b1);
    #1;
    check("pre_reset_rd", bus.read_data, 32'd62);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear_rd", bus.read_data, 32'd0);
    drive(32'd3, 32'd77, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("write_in_reset_rd", bus.read_data, 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    drive(32'd258, 32'd77, 1'b1, 1'b1);
    #1;
    check("err_in_reset", {31'd0, bus.err}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'd3, 32'd77, 1'b1, 1'b1);
    #1;
    check("post_release_pre_edge", bus.read_data, 32'd0);
    @(posedge clk);
    #1;
    check("post_release_first_write", bus.read_data, 32'd77);
    $display("reset sequence addr=3 rd=%0d", bus.read_data);

    // Random traffic against the array model, starting from a fresh reset.
    @(negedge clk);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    for (int w = 0; w < DEPTH; w++) model[w] = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? 32'd256 : 32'd0);
      wd = $urandom();
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      drive(a, wd, we, re);
      #1;
      if (!re || out_of_range(a)) exp_rd = 32'd0;
      else exp_rd = model[a % DEPTH];
      nm = $sformatf("rand%0d_rd", n);
      check(nm, bus.read_data, exp_rd);
`ifdef DMEM_BOUNDS_CHECK_EN
      nm = $sformatf("rand%0d_err", n);
      check(nm, {31'd0, bus.err}, {31'd0, (we | re) & out_of_range(a)});
`endif
      $display("rand %0d addr=%0d wd=%0d we=%0b re=%0b rd=%0d", n, a, wd, we, re, bus.read_data);
      @(posedge clk);
      if (we && !out_of_range(a)) model[a % DEPTH] = wd;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
